// File: rtl/hit_arbiter.sv
// Round controller for a two-player fighter: grants at most one attack per frame,
// tracks health, hitstun, cooldown, round timer and best-of-3 scoring.
module hit_arbiter #(
  parameter int unsigned DAMAGE       = 10,
  parameter int unsigned HEALTH_MAX   = 100,
  parameter int unsigned HITSTUN      = 12,
  parameter int unsigned COOLDOWN     = 8,
  parameter int unsigned ROUND_SECS   = 99,
  parameter int unsigned FPS          = 60,
  parameter int unsigned INTRO_FRAMES = 90,
  parameter int unsigned KO_HOLD      = 120
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       p1_atk,
  input  logic       p2_atk,
  input  logic       p1_in_range,
  input  logic       p2_in_range,
  output logic       p1_hit,
  output logic       p2_hit,
  output logic [7:0] p1_health,
  output logic [7:0] p2_health,
  output logic       p1_stun,
  output logic       p2_stun,
  output logic [2:0] round_state,
  output logic [6:0] timer,
  output logic [1:0] p1_wins,
  output logic [1:0] p2_wins,
  output logic [1:0] winner
);

  localparam int unsigned CNT_MAX   = (HITSTUN > COOLDOWN) ? HITSTUN : COOLDOWN;
  localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
  localparam int unsigned PHASE_MAX = (INTRO_FRAMES > KO_HOLD) ? INTRO_FRAMES : KO_HOLD;
  localparam int unsigned PHASE_W   = $clog2(PHASE_MAX + 1);
  localparam int unsigned FRAME_W   = $clog2(FPS + 1);

  typedef enum logic [2:0] {
    ST_INTRO      = 3'd0,
    ST_FIGHT      = 3'd1,
    ST_KO         = 3'd2,
    ST_TIMEOUT    = 3'd3,
    ST_MATCH_OVER = 3'd4
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     stun1, stun2, cd1, cd2;
  logic [PHASE_W-1:0]   phase_cnt;
  logic [FRAME_W-1:0]   frame_cnt;
  logic                 prev1, prev2;
  logic                 last_grant;   // 0 = P1, 1 = P2

  logic                 fight_live, v1, v2, g1, g2, land1, land2, wrap, timeout_now;
  logic [7:0]           nh1, nh2;

  function automatic logic [7:0] take_hit(input logic [7:0] h);
    return (h > 8'(DAMAGE)) ? h - 8'(DAMAGE) : 8'd0;
  endfunction

  function automatic logic [CNT_W-1:0] dec_sat(input logic [CNT_W-1:0] c);
    return (c == '0) ? '0 : c - CNT_W'(1);
  endfunction

  function automatic logic [1:0] inc_win(input logic [1:0] w);
    return (w == 2'd2) ? 2'd2 : w + 2'd1;
  endfunction

  assign round_state = state;
  assign p1_stun     = (stun1 != '0);
  assign p2_stun     = (stun2 != '0);

  // Request qualification, round-robin tie break and the resulting health/timeout outcome
  always_comb begin
    fight_live  = (state == ST_FIGHT) && (p1_health != 8'd0) && (p2_health != 8'd0);
    v1          = fight_live && p1_atk && !prev1 && (stun1 == '0) && (cd1 == '0);
    v2          = fight_live && p2_atk && !prev2 && (stun2 == '0) && (cd2 == '0);
    g1          = v1 && (!v2 || last_grant);
    g2          = v2 && !g1;
    land1       = g1 && p1_in_range;
    land2       = g2 && p2_in_range;
    nh1         = land2 ? take_hit(p1_health) : p1_health;
    nh2         = land1 ? take_hit(p2_health) : p2_health;
    wrap        = (frame_cnt == FRAME_W'(FPS - 1));
    // a hit that empties a health bar defers to KO on the following tick
    timeout_now = fight_live && wrap && (timer == 7'd1) && (nh1 != 8'd0) && (nh2 != 8'd0);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= ST_INTRO;
      p1_health  <= 8'(HEALTH_MAX);
      p2_health  <= 8'(HEALTH_MAX);
      timer      <= 7'(ROUND_SECS);
      p1_wins    <= 2'd0;
      p2_wins    <= 2'd0;
      winner     <= 2'd0;
      p1_hit     <= 1'b0;
      p2_hit     <= 1'b0;
      stun1      <= '0;
      stun2      <= '0;
      cd1        <= '0;
      cd2        <= '0;
      phase_cnt  <= '0;
      frame_cnt  <= '0;
      prev1      <= 1'b0;
      prev2      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      p1_hit <= 1'b0;
      p2_hit <= 1'b0;
      if (frame_tick) begin
        prev1 <= p1_atk;
        prev2 <= p2_atk;
        if (state != ST_MATCH_OVER) begin
          stun1 <= dec_sat(stun1);
          stun2 <= dec_sat(stun2);
          cd1   <= dec_sat(cd1);
          cd2   <= dec_sat(cd2);
        end
        case (state)
          ST_INTRO: begin
            if (phase_cnt == PHASE_W'(INTRO_FRAMES - 1)) begin
              phase_cnt <= '0;
              frame_cnt <= '0;
              state     <= ST_FIGHT;
            end else begin
              phase_cnt <= phase_cnt + PHASE_W'(1);
            end
          end
          ST_FIGHT: begin
            if ((p1_health == 8'd0) || (p2_health == 8'd0)) begin
              state     <= ST_KO;
              phase_cnt <= '0;
              if (p2_health == 8'd0) begin
                p1_wins <= inc_win(p1_wins);
                winner  <= 2'd1;
              end else begin
                p2_wins <= inc_win(p2_wins);
                winner  <= 2'd2;
              end
            end else begin
              if (g1 || g2) last_grant <= g2;
              if (g1) cd1 <= CNT_W'(COOLDOWN);
              if (g2) cd2 <= CNT_W'(COOLDOWN);
              if (land1) begin
                p2_health <= nh2;
                stun2     <= CNT_W'(HITSTUN);
                p2_hit    <= 1'b1;
              end
              if (land2) begin
                p1_health <= nh1;
                stun1     <= CNT_W'(HITSTUN);
                p1_hit    <= 1'b1;
              end
              frame_cnt <= wrap ? '0 : frame_cnt + FRAME_W'(1);
              if (wrap && (timer != 7'd0)) timer <= timer - 7'd1;
              if (timeout_now) begin
                state     <= ST_TIMEOUT;
                phase_cnt <= '0;
                if (nh1 > nh2) begin
                  p1_wins <= inc_win(p1_wins);
                  winner  <= 2'd1;
                end else if (nh2 > nh1) begin
                  p2_wins <= inc_win(p2_wins);
                  winner  <= 2'd2;
                end else begin
                  winner  <= 2'd0;
                end
              end
            end
          end
          ST_KO, ST_TIMEOUT: begin
            if (phase_cnt == PHASE_W'(KO_HOLD - 1)) begin
              phase_cnt <= '0;
              if ((p1_wins == 2'd2) || (p2_wins == 2'd2)) begin
                state <= ST_MATCH_OVER;
              end else begin
                state     <= ST_INTRO;
                p1_health <= 8'(HEALTH_MAX);
                p2_health <= 8'(HEALTH_MAX);
                timer     <= 7'(ROUND_SECS);
                stun1     <= '0;
                stun2     <= '0;
                cd1       <= '0;
                cd2       <= '0;
                frame_cnt <= '0;
              end
            end else begin
              phase_cnt <= phase_cnt + PHASE_W'(1);
            end
          end
          ST_MATCH_OVER: begin
          end
          default: state <= ST_INTRO;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hit_arbiter.sv
// Directed bench for hit_arbiter: walks a full best-of-3 match with hand-computed values.
module tb_hit_arbiter;

  logic       Clk = 1'b0;
  logic       Reset, frame_tick, p1_atk, p2_atk, p1_in_range, p2_in_range;
  logic       p1_hit, p2_hit, p1_stun, p2_stun;
  logic [7:0] p1_health, p2_health;
  logic [2:0] round_state;
  logic [6:0] timer;
  logic [1:0] p1_wins, p2_wins, winner;

  int checks = 0;
  int errors = 0;
  int nhit;

  hit_arbiter dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick),
    .p1_atk(p1_atk), .p2_atk(p2_atk),
    .p1_in_range(p1_in_range), .p2_in_range(p2_in_range),
    .p1_hit(p1_hit), .p2_hit(p2_hit),
    .p1_health(p1_health), .p2_health(p2_health),
    .p1_stun(p1_stun), .p2_stun(p2_stun),
    .round_state(round_state), .timer(timer),
    .p1_wins(p1_wins), .p2_wins(p2_wins), .winner(winner)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One frame strobe; returns at the falling edge right after the strobed rising edge.
  task automatic tick();
    @(negedge Clk) frame_tick = 1'b1;
    @(negedge Clk) frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic hit_p1();
    p1_atk = 1'b1;
    tick();
    p1_atk = 1'b0;
    tick();
  endtask

  task automatic check_fresh(input string tag);
    check({tag, "_state"}, 32'(round_state), 0);
    check({tag, "_p1_health"}, 32'(p1_health), 100);
    check({tag, "_p2_health"}, 32'(p2_health), 100);
    check({tag, "_timer"}, 32'(timer), 99);
    check({tag, "_stun"}, 32'({p1_stun, p2_stun}), 0);
  endtask

  initial begin
    Reset = 1'b1; frame_tick = 1'b0; p1_atk = 1'b0; p2_atk = 1'b0;
    p1_in_range = 1'b1; p2_in_range = 1'b1;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    check_fresh("reset");
    check("reset_wins", 32'({p1_wins, p2_wins}), 0);
    check("reset_winner", 32'(winner), 0);
    check("reset_hits", 32'({p1_hit, p2_hit}), 0);

    // Round 1: intro then simultaneous presses; P1 takes the first tie
    ticks(89);
    check("intro_89", 32'(round_state), 0);
    tick();
    check("fight_entry", 32'(round_state), 1);
    p1_atk = 1'b1; p2_atk = 1'b1;
    tick();
    check("tie1_p2_hit", 32'(p2_hit), 1);
    check("tie1_p1_hit", 32'(p1_hit), 0);
    check("tie1_p2_health", 32'(p2_health), 90);
    check("tie1_p1_health", 32'(p1_health), 100);
    check("tie1_p2_stun", 32'(p2_stun), 1);
    @(negedge Clk);
    check("tie1_pulse_clear", 32'(p2_hit), 0);
    p1_atk = 1'b0; p2_atk = 1'b0;
    ticks(11);
    check("stun_tick11", 32'(p2_stun), 1);
    tick();
    check("stun_tick12", 32'(p2_stun), 0);

    // Second tie goes to P2 by round robin
    p1_atk = 1'b1; p2_atk = 1'b1;
    tick();
    check("tie2_p1_hit", 32'(p1_hit), 1);
    check("tie2_p2_hit", 32'(p2_hit), 0);
    check("tie2_p1_health", 32'(p1_health), 90);
    check("tie2_p2_health", 32'(p2_health), 90);
    p1_atk = 1'b0; p2_atk = 1'b0;
    ticks(12);

    // Held button fires once; a re-press inside the cooldown is dropped
    p1_atk = 1'b1;
    nhit = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      nhit = nhit + int'(p2_hit);
    end
    check("held_hits", 32'(nhit), 1);
    check("held_p2_health", 32'(p2_health), 80);
    p1_atk = 1'b0;
    tick();
    hit_p1();
    check("repress_p2_health", 32'(p2_health), 70);
    p1_atk = 1'b1;
    tick();
    check("cooldown_no_hit", 32'(p2_hit), 0);
    check("cooldown_p2_health", 32'(p2_health), 70);
    p1_atk = 1'b0;
    tick();
    ticks(6);

    // Seven more hits knock P2 out
    for (int i = 0; i < 7; i++) begin
      hit_p1();
      if (i < 6) ticks(7);
    end
    check("ko1_state", 32'(round_state), 2);
    check("ko1_p2_health", 32'(p2_health), 0);
    check("ko1_p1_wins", 32'(p1_wins), 1);
    check("ko1_winner", 32'(winner), 1);
    ticks(119);
    check("ko1_hold", 32'(round_state), 2);
    tick();
    check_fresh("round2");
    check("round2_p1_wins", 32'(p1_wins), 1);

    // Round 2: idle until the clock runs out with equal health
    ticks(90);
    check("r2_fight", 32'(round_state), 1);
    ticks(59);
    check("timer_59", 32'(timer), 99);
    tick();
    check("timer_60", 32'(timer), 98);
    ticks(5820);
    check("timer_last_sec", 32'(timer), 1);
    ticks(59);
    check("timer_pre_timeout", 32'(round_state), 1);
    tick();
    check("timeout_state", 32'(round_state), 3);
    check("timeout_timer", 32'(timer), 0);
    check("timeout_winner", 32'(winner), 0);
    check("timeout_wins", 32'({p1_wins, p2_wins}), 32'({2'd1, 2'd0}));
    ticks(120);
    check_fresh("round3");

    // Round 3: P2 whiffs out of range, then P1 wins the match
    ticks(90);
    p2_in_range = 1'b0;
    p2_atk = 1'b1;
    tick();
    check("whiff_p1_hit", 32'(p1_hit), 0);
    check("whiff_p1_health", 32'(p1_health), 100);
    p2_atk = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      hit_p1();
      if (i < 9) ticks(7);
    end
    check("ko2_state", 32'(round_state), 2);
    check("ko2_p1_wins", 32'(p1_wins), 2);
    check("ko2_winner", 32'(winner), 1);
    ticks(120);
    check("match_over", 32'(round_state), 4);

    // Match over: inputs are ignored
    p2_in_range = 1'b1;
    nhit = 0;
    for (int i = 0; i < 6; i++) begin
      p1_atk = ~p1_atk; p2_atk = ~p2_atk;
      tick();
      nhit = nhit + int'(p1_hit) + int'(p2_hit);
    end
    p1_atk = 1'b0; p2_atk = 1'b0;
    check("mo_hits", 32'(nhit), 0);
    check("mo_state", 32'(round_state), 4);
    check("mo_healths", 32'({p1_health, p2_health}), 32'({8'd100, 8'd0}));
    check("mo_p1_wins", 32'(p1_wins), 2);

    // Reset mid-match overrides a coincident frame strobe
    @(negedge Clk);
    Reset = 1'b1; frame_tick = 1'b1;
    @(negedge Clk);
    Reset = 1'b0; frame_tick = 1'b0;
    check_fresh("rst2");
    check("rst2_wins", 32'({p1_wins, p2_wins}), 0);
    check("rst2_winner", 32'(winner), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hit_arbiter.md
Name: hit_arbiter

Overview:
- Combat/round controller between the per-player attack logic and the health-bar/movement blocks.
- Arbitrates attack requests from both fighters and grants at most one hit per frame.
- Owns both health values, hitstun lockouts, the round countdown timer, KO/timeout detection and best-of-3 win counting.
- Runs on the system clock, qualified by a one-cycle frame strobe.

Parameters:
- DAMAGE, 10: health removed per landed hit (8-bit).
- HEALTH_MAX, 100: health at round start (8-bit, ≤255).
- HITSTUN, 12: frames the victim is locked out after a hit.
- COOLDOWN, 8: frames an attacker waits after any grant (hit or whiff).
- ROUND_SECS, 99: round timer start value, in seconds.
- FPS, 60: frame ticks per timer second.
- INTRO_FRAMES, 90: frames spent in INTRO before FIGHT.
- KO_HOLD, 120: frames spent in KO/TIMEOUT before the next round.

Ports:
- Clk, in, 1: system clock.
- Reset, in, 1: synchronous, active-high.
- frame_tick, in, 1: one-Clk pulse per video frame.
- p1_atk, in, 1: player 1 attack request (level).
- p2_atk, in, 1: player 2 attack request (level).
- p1_in_range, in, 1: player 2 is within player 1's reach.
- p2_in_range, in, 1: player 1 is within player 2's reach.
- p1_hit, out, 1: one-Clk pulse, player 1 took damage.
- p2_hit, out, 1: one-Clk pulse, player 2 took damage.
- p1_health, out, 8: player 1 health.
- p2_health, out, 8: player 2 health.
- p1_stun, out, 1: player 1 in hitstun (movement/knockback active).
- p2_stun, out, 1: player 2 in hitstun.
- round_state, out, 3: 0 INTRO, 1 FIGHT, 2 KO, 3 TIMEOUT, 4 MATCH_OVER.
- timer, out, 7: seconds remaining.
- p1_wins, out, 2: rounds won by player 1.
- p2_wins, out, 2: rounds won by player 2.
- winner, out, 2: 0 none/draw, 1 P1, 2 P2 (last decided round or match).

Behaviour:
- Single clock Clk; Reset is synchronous and active-high and overrides frame_tick.
- Reset values:
  - healths = HEALTH_MAX; timer = ROUND_SECS.
  - round_state = INTRO; wins = 0; winner = 0.
  - hit pulses, stun, cooldowns, frame/sec counters = 0.
  - last_grant = P2, so P1 wins the first tie.
- All state advances only on Clk edges where frame_tick = 1, except that hit pulses clear on the next Clk.
- Request edge detection:
  - prev_atk per player is sampled on each frame_tick.
  - A request is valid when atk = 1 AND prev_atk = 0 AND stun = 0 AND cooldown = 0 AND round_state = FIGHT.
- Arbitration:
  - One valid request: grant it.
  - Both valid: grant the player ≠ last_grant (round-robin); the other request is dropped, not queued.
  - last_grant updates on every grant.
- On grant:
  - The attacker's cooldown loads COOLDOWN.
  - If attacker's in_range = 1: the victim's health -= DAMAGE, saturating at 0; the victim's stun counter loads HITSTUN; the victim's hit pulse is high for exactly the Clk cycle after the tick, coincident with the new health value.
  - Out of range (whiff): cooldown only.
- Stun and cooldown counters decrement by 1 per tick and saturate at 0. stun output = (counter ≠ 0).
- Timer (FIGHT only):
  - The frame counter counts 0..FPS-1; on wrap, timer decrements.
  - Timer reaching 0 → TIMEOUT on that tick.
- State transitions:
  - INTRO: after INTRO_FRAMES ticks → FIGHT.
  - FIGHT → KO when either health = 0, evaluated on the tick after the damaging tick.
  - KO has priority over TIMEOUT if both occur on the same tick.
  - Entering KO: the survivor's wins += 1 (saturate at 2); winner = survivor.
  - Entering TIMEOUT:
    - Higher health wins (wins += 1, winner set).
    - Equal health = draw: winner = 0, no win credited.
  - KO/TIMEOUT: after KO_HOLD ticks:
    - If either wins = 2 → MATCH_OVER.
    - Else reload healths, timer, stun, cooldown and counters → INTRO.
  - MATCH_OVER: holds all outputs until Reset; requests ignored.
- Requests outside FIGHT: ignored, but prev_atk is still sampled, so a held button never fires on FIGHT entry.

Test Plan:
- Reset, 90 ticks, p1_atk rises with p1_in_range=1 → round_state=1; next Clk p2_hit=1 for 1 cycle, p2_health=90, p2_stun=1 for 12 ticks.
- Both atk rise on the same tick, both in range, twice (spaced >12 ticks) → first P1 lands (p2_health=90), second P2 lands (p1_health=90); the loser is dropped both times.
- p1_atk held high 30 ticks → exactly one hit; re-press during cooldown (<8 ticks) → no hit.
- Ten P1 hits → p2_health=0, round_state=2, p1_wins=1, winner=1; after 120 ticks → INTRO, healths=100, timer=99.
- No attacks for 99×60 ticks with equal health → TIMEOUT, winner=0, wins unchanged.
- P1 wins two KO rounds → MATCH_OVER, p1_wins=2; further requests change nothing; Reset asserted mid-match → all reset values next Clk.
